// File: rtl/umi_to_sb_packer_if.sv
// UMI request stream and sb packet stream grouped for the umi_to_sb_packer bridge.
// The slave modport is the packer's view; the master modport is the surrounding environment's view.
interface umi_to_sb_packer_if #(
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32
);
  logic                     umi_valid;
  logic                     umi_ready;
  logic [CW-1:0]            umi_cmd;
  logic [AW-1:0]            umi_dstaddr;
  logic [AW-1:0]            umi_srcaddr;
  logic [DW-1:0]            umi_data;
  logic                     sb_valid;
  logic                     sb_ready;
  logic [DW+2*AW+CW-1:0]    sb_data;
  logic [31:0]              sb_dest;
  logic                     sb_last;

  modport master (
    output umi_valid, umi_cmd, umi_dstaddr, umi_srcaddr, umi_data, sb_ready,
    input  umi_ready, sb_valid, sb_data, sb_dest, sb_last
  );

  modport slave (
    input  umi_valid, umi_cmd, umi_dstaddr, umi_srcaddr, umi_data, sb_ready,
    output umi_ready, sb_valid, sb_data, sb_dest, sb_last
  );
endinterface

// File: rtl/umi_to_sb_packer.sv
// Buffered UMI to sb converter: elastic FIFO, EOM-driven burst grouping with a burst-locked destination.
// Optional counters stat_flits/stat_pkts/stat_stall are enabled by defining UMI_TO_SB_PACKER_STATS_EN.
module umi_to_sb_packer #(
  parameter int DW       = 256,
  parameter int AW       = 64,
  parameter int CW       = 32,
  parameter int DEPTH    = 4,
  parameter int DEST_LSB = 40,
  parameter int DEST_W   = 16,
  parameter int EOM_BIT  = 22
) (
  input  logic               clk,
  input  logic               rst,
  umi_to_sb_packer_if.slave  bus,
  output logic               in_burst,
  output logic               dest_err
`ifdef UMI_TO_SB_PACKER_STATS_EN
  ,
  output logic [31:0]        stat_flits,
  output logic [31:0]        stat_pkts,
  output logic [31:0]        stat_stall
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int SBW = DW + 2*AW + CW;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ZERO = {(PW+1){1'b0}};

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  logic [SBW-1:0]    data_mem_r [DEPTH];
  logic [DEST_W-1:0] dest_mem_r [DEPTH];
  logic [DEPTH-1:0]  last_mem_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW:0]       count_r;
  logic [PW:0]       count_next_s;
  logic              full_r;
  state_t            state_r;
  state_t            state_next_s;
  logic [DEST_W-1:0] dest_lock_r;
  logic [DEST_W-1:0] dest_lock_next_s;
  logic [DEST_W-1:0] slice_s;
  logic [DEST_W-1:0] push_dest_s;
  logic              dest_err_r;
  logic              dest_err_next_s;
  logic              push_s;
  logic              pop_s;
  logic              eom_s;

  assign slice_s  = bus.umi_dstaddr[DEST_LSB +: DEST_W];
  assign eom_s    = bus.umi_cmd[EOM_BIT];
  assign push_s   = bus.umi_valid & bus.umi_ready;
  assign pop_s    = bus.sb_valid & bus.sb_ready;

  // Ready comes only from registered fullness, so sb_ready never reaches umi_ready in the same cycle.
  assign bus.umi_ready = ~rst & ~full_r;
  assign bus.sb_valid  = (count_r != CNT_ZERO);
  assign bus.sb_data   = data_mem_r[rd_ptr_r];
  assign bus.sb_dest   = 32'(dest_mem_r[rd_ptr_r]);
  assign bus.sb_last   = last_mem_r[rd_ptr_r];
  assign in_burst      = (state_r == BURST);
  assign dest_err      = dest_err_r;

  // Occupancy update from push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + (PW+1)'(1);
      2'b01:   count_next_s = count_r - (PW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Burst FSM: advances on UMI accepts only and picks the destination stored with each flit.
  always_comb begin
    state_next_s     = state_r;
    dest_lock_next_s = dest_lock_r;
    dest_err_next_s  = dest_err_r;
    push_dest_s      = slice_s;
    case (state_r)
      IDLE: begin
        push_dest_s = slice_s;
        if (push_s && !eom_s) begin
          state_next_s     = BURST;
          dest_lock_next_s = slice_s;
        end else begin
          state_next_s     = IDLE;
        end
      end
      BURST: begin
        push_dest_s = dest_lock_r;
        if (push_s) begin
          if (slice_s != dest_lock_r) begin
            dest_err_next_s = 1'b1;
          end else begin
            dest_err_next_s = dest_err_r;
          end
          state_next_s = eom_s ? IDLE : BURST;
        end else begin
          state_next_s = BURST;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Control state: pointers, count, fullness, FSM, lock and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= CNT_ZERO;
      full_r      <= 1'b0;
      state_r     <= IDLE;
      dest_lock_r <= {DEST_W{1'b0}};
      dest_err_r  <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r     <= count_next_s;
      full_r      <= (count_next_s == CNT_FULL);
      state_r     <= state_next_s;
      dest_lock_r <= dest_lock_next_s;
      dest_err_r  <= dest_err_next_s;
    end
  end

  // Entry storage; destination and last are captured at push time.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= {bus.umi_data, bus.umi_srcaddr, bus.umi_dstaddr, bus.umi_cmd};
      dest_mem_r[wr_ptr_r] <= push_dest_s;
      last_mem_r[wr_ptr_r] <= eom_s;
    end
  end

`ifdef UMI_TO_SB_PACKER_STATS_EN
  // Free-running traffic counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flits <= 32'd0;
      stat_pkts  <= 32'd0;
      stat_stall <= 32'd0;
    end else begin
      if (pop_s)                   stat_flits <= stat_flits + 32'd1;
      if (pop_s && bus.sb_last)    stat_pkts  <= stat_pkts + 32'd1;
      if (bus.sb_valid && !bus.sb_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_umi_to_sb_packer.sv
// Self-checking bench for umi_to_sb_packer: scoreboard of expected sb flits plus per-scenario checks.
module tb_umi_to_sb_packer;
  localparam int DW = 256, AW = 64, CW = 32, DEPTH = 4;
  localparam int DEST_LSB = 40, DEST_W = 16, EOM_BIT = 22;
  localparam int SBW = DW + 2*AW + CW;
  localparam int EW  = SBW + 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_burst, dest_err;
`ifdef UMI_TO_SB_PACKER_STATS_EN
  logic [31:0] stat_flits, stat_pkts, stat_stall;
`endif

  always #5 clk = ~clk;

  umi_to_sb_packer_if #(.DW(DW), .AW(AW), .CW(CW)) bus();

  umi_to_sb_packer #(
    .DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH),
    .DEST_LSB(DEST_LSB), .DEST_W(DEST_W), .EOM_BIT(EOM_BIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .in_burst(in_burst),
    .dest_err(dest_err)
`ifdef UMI_TO_SB_PACKER_STATS_EN
    ,
    .stat_flits(stat_flits),
    .stat_pkts(stat_pkts),
    .stat_stall(stat_stall)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] sbq[$];
  logic [EW-1:0] mon_exp, mon_got;
  logic              m_burst = 1'b0;
  logic [DEST_W-1:0] m_lock  = '0;
  logic              m_err   = 1'b0;

  // sb-side monitor: every transfer is compared with the oldest expected flit.
  always @(negedge clk) begin
    if (!rst && bus.sb_valid && bus.sb_ready) begin
      checks++;
      mon_got = {bus.sb_data, bus.sb_dest, bus.sb_last};
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got dest=%h last=%b with nothing expected", bus.sb_dest, bus.sb_last);
      end else begin
        mon_exp = sbq.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL sb_flit: got %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic umi_idle();
    bus.umi_valid = 1'b0;
  endtask

  task automatic model_reset();
    sbq.delete();
    m_burst = 1'b0;
    m_lock  = '0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    bus.umi_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one flit, waits for acceptance and records the expected sb flit; valid is left high.
  task automatic push_flit(input logic eom, input logic [DEST_W-1:0] slice, output int waits);
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst, src;
    logic [DW-1:0] data;
    logic [DEST_W-1:0] exp_dest;
    bit accepted;
    cmd = $urandom();
    cmd[EOM_BIT] = eom;
    dst = {$urandom(), $urandom()};
    dst[DEST_LSB +: DEST_W] = slice;
    src = {$urandom(), $urandom()};
    for (int i = 0; i < DW/32; i++) data[i*32 +: 32] = $urandom();
    bus.umi_cmd = cmd;
    bus.umi_dstaddr = dst;
    bus.umi_srcaddr = src;
    bus.umi_data = data;
    bus.umi_valid = 1'b1;
    waits = 0;
    accepted = 1'b0;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      if (bus.umi_ready) begin
        accepted = 1'b1;
        exp_dest = m_burst ? m_lock : slice;
        if (m_burst && slice != m_lock) m_err = 1'b1;
        if (!m_burst && !eom) begin
          m_burst = 1'b1;
          m_lock = slice;
        end else if (m_burst && eom) begin
          m_burst = 1'b0;
        end
        sbq.push_back({data, src, dst, cmd, 32'(exp_dest), eom});
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: umi_ready never seen, slice=%h", slice);
    end
  endtask

  task automatic wait_drain(input string name);
    int c;
    for (c = 0; c < 100; c++) begin
      if (sbq.size() == 0 && !bus.sb_valid) break;
      tick();
    end
    checks++;
    if (sbq.size() != 0 || bus.sb_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending sb_valid=%b expected 0 pending sb_valid=0", name, sbq.size(), bus.sb_valid);
    end
  endtask

  task automatic test_reset();
    bus.sb_ready = 1'b0;
    bus.umi_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (bus.umi_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", bus.umi_ready); end
    checks++;
    if ({bus.sb_valid, in_burst, dest_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got valid/burst/err=%b%b%b expected 000", bus.sb_valid, in_burst, dest_err);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.umi_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b expected 1", bus.umi_ready); end
    tick();
  endtask

  task automatic test_single();
    int w;
    bus.sb_ready = 1'b1;
    checks++;
    if (bus.sb_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %b expected 0", bus.sb_valid); end
    push_flit(1'b1, 16'h0012, w);
    checks++;
    if (bus.sb_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got sb_valid=%b expected 1", bus.sb_valid); end
    push_flit(1'b1, 16'h0012, w);
    push_flit(1'b1, 16'h0012, w);
    umi_idle();
    checks++;
    if (in_burst !== 1'b0) begin errors++; $display("FAIL single_in_burst: got %b expected 0", in_burst); end
    wait_drain("single");
  endtask

  task automatic test_backpressure();
    int w;
    bus.sb_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_flit(1'b1, 16'h0100 + 16'(i), w);
    umi_idle();
    checks++;
    if (bus.umi_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got umi_ready=%b expected 0", bus.umi_ready); end
    tick();
    bus.sb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.umi_ready !== 1'b0) begin errors++; $display("FAIL bp_passthrough: got umi_ready=%b expected 0", bus.umi_ready); end
    @(posedge clk);
    #1;
    bus.sb_ready = 1'b0;
    checks++;
    if (bus.umi_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen: got umi_ready=%b expected 1", bus.umi_ready); end
    push_flit(1'b1, 16'h0104, w);
    umi_idle();
    checks++;
    if (w !== 0 || bus.umi_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_fifth: got waits=%0d umi_ready=%b expected 0 and 0", w, bus.umi_ready);
    end
    bus.sb_ready = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_burst();
    int w;
    bus.sb_ready = 1'b1;
    push_flit(1'b0, 16'h0034, w);
    checks++;
    if (in_burst !== 1'b1) begin errors++; $display("FAIL burst_start: got in_burst=%b expected 1", in_burst); end
    push_flit(1'b0, 16'h0034, w);
    checks++;
    if (in_burst !== 1'b1) begin errors++; $display("FAIL burst_mid: got in_burst=%b expected 1", in_burst); end
    push_flit(1'b1, 16'h0034, w);
    umi_idle();
    checks++;
    if (in_burst !== 1'b0 || dest_err !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: got in_burst=%b dest_err=%b expected 0 0", in_burst, dest_err);
    end
    wait_drain("burst");
  endtask

  task automatic test_dest_change();
    int w;
    bus.sb_ready = 1'b1;
    push_flit(1'b0, 16'h0034, w);
    push_flit(1'b1, 16'h0077, w);
    umi_idle();
    checks++;
    if (dest_err !== 1'b1 || in_burst !== 1'b0) begin
      errors++;
      $display("FAIL dest_change_err: got dest_err=%b in_burst=%b expected 1 0", dest_err, in_burst);
    end
    push_flit(1'b1, 16'h0050, w);
    umi_idle();
    wait_drain("dest_change");
    checks++;
    if (dest_err !== 1'b1) begin errors++; $display("FAIL dest_err_sticky: got %b expected 1", dest_err); end
  endtask

  task automatic test_back_to_back();
    int w, total;
    total = 0;
    bus.sb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_flit((i % 4) == 3, 16'h0abc, w);
      total += w;
    end
    umi_idle();
    checks++;
    if (total != 0) begin errors++; $display("FAIL b2b_stall: got %0d wait cycles expected 0", total); end
    wait_drain("b2b");
    checks++;
    if (dest_err !== m_err) begin errors++; $display("FAIL b2b_dest_err: got %b expected %b", dest_err, m_err); end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    bus.sb_ready = 1'b0;
    push_flit(1'b0, 16'h0021, w);
    push_flit(1'b0, 16'h0021, w);
    umi_idle();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.umi_ready !== 1'b0) begin errors++; $display("FAIL rmb_ready: got %b expected 0", bus.umi_ready); end
    tick();
    rst = 1'b0;
    model_reset();
    checks++;
    if ({bus.sb_valid, in_burst, dest_err} !== 3'b000) begin
      errors++;
      $display("FAIL rmb_state: got valid/burst/err=%b%b%b expected 000", bus.sb_valid, in_burst, dest_err);
    end
    bus.sb_ready = 1'b1;
    push_flit(1'b1, 16'h0005, w);
    umi_idle();
    wait_drain("rmb");
  endtask

`ifdef UMI_TO_SB_PACKER_STATS_EN
  task automatic test_stats();
    int w;
    bus.sb_ready = 1'b0;
    do_reset();
    checks++;
    if ({stat_flits, stat_pkts, stat_stall} !== 96'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d %0d %0d expected 0 0 0", stat_flits, stat_pkts, stat_stall);
    end
    push_flit(1'b0, 16'h0009, w);
    push_flit(1'b1, 16'h0009, w);
    push_flit(1'b1, 16'h000a, w);
    umi_idle();
    tick();
    bus.sb_ready = 1'b1;
    wait_drain("stats");
    checks++;
    if (stat_flits !== 32'd3 || stat_pkts !== 32'd2 || stat_stall !== 32'd3) begin
      errors++;
      $display("FAIL stats_counts: got flits=%0d pkts=%0d stall=%0d expected 3 2 3", stat_flits, stat_pkts, stat_stall);
    end
  endtask
`endif

  initial begin
    bus.umi_valid = 1'b0;
    bus.umi_cmd = '0;
    bus.umi_dstaddr = '0;
    bus.umi_srcaddr = '0;
    bus.umi_data = '0;
    bus.sb_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_burst();
    test_dest_change();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef UMI_TO_SB_PACKER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
